ifetch_unit: RTL and testbench
==============================

Name: ifetch_unit

Overview:
- Instruction fetch stage directly downstream of the program counter register.
- Takes the current PC value and issues in-order instruction-memory read requests.
- Buffers returned instructions in a small queue for decode.
- Drives the PC stall input: the PC advances only when a fetch request is accepted, or when a redirect must be loaded.

Parameters:
XLEN, 32, address/instruction width; set to `DataBusBits at instantiation
DEPTH, 2, instruction-queue and in-flight-request capacity; power of 2, >=2

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
pc_addr  in  XLEN  current PC value (PC register output)
redirect  in  1  branch/jump taken this cycle; same signal as PC load-address strobe
pc_stall  out  1  hold PC when 1
req_valid  out  1  imem read request valid
req_addr  out  XLEN  imem read address (= pc_addr)
req_ready  in  1  imem accepts request
rsp_valid  in  1  imem read data valid; no backpressure, responses in order
rsp_data  in  XLEN  instruction word
inst_valid  out  1  queue head valid to decode
inst_data  out  XLEN  instruction at queue head
inst_pc  out  XLEN  address of instruction at queue head
inst_ready  in  1  decode consumes head

Behaviour:
- Reset (reset=0, async): queue empty, addr FIFO empty, inflight=0, discard=0. Outputs: inst_valid=0, inst_data=0, inst_pc=0, req_valid=0, pc_stall=1.
- Credit: credit = (inflight + count < DEPTH). count = queue occupancy. inflight = issued requests not yet responded, including stale ones.
- req_valid = credit & ~redirect. req_addr = pc_addr, combinational.
- fire = req_valid & req_ready.
- pc_stall = ~(fire | redirect).
  - PC increments by 4 only on an accepted request.
  - On redirect, stall drops so the PC loads the target the same cycle.
- On fire: push pc_addr into the address FIFO (depth DEPTH); inflight += 1.
- On rsp_valid: pop the address FIFO; inflight -= 1.
  - If discard>0: drop the word; discard -= 1.
  - Else: push {pc, rsp_data} into the instruction queue.
  - Fire and response in the same cycle: inflight unchanged.
- Redirect (flush), single cycle:
  - Instruction queue cleared; head contents are not consumed even if inst_ready=1.
  - discard <= discard + (inflight - discard) - rsp_valid_counted, i.e. all still-pending requests become stale. A response arriving in the flush cycle is itself dropped.
  - No request issued in the flush cycle. Next cycle fetches from the new pc_addr.
- Queue pop: inst_valid & inst_ready; head advances the next cycle.
  - Push and pop in the same cycle are allowed; count unchanged.
- Latency: without bypass, a response is visible on inst_valid 1 cycle after rsp_valid.
- Full queue: credit=0, so req_valid=0 and pc_stall=1 until decode pops.
- rsp_valid with inflight=0 is illegal; simulation assertion only, no RTL response required.
- Queue overflow is impossible by the credit rule; assert in simulation.
- Reset mid-operation: all state cleared immediately. Pending imem responses after reset release are the memory's responsibility (the memory shares reset).
- Pointers wrap modulo DEPTH. Counters are clog2(DEPTH)+1 bits and never exceed DEPTH.

Optional Feature:
- Macro: IFETCH_BYPASS_EN.
- Defined:
  - When the queue is empty, discard=0 and rsp_valid=1, the response drives inst_valid/inst_data/inst_pc combinationally the same cycle.
  - If inst_ready=1 that cycle, the word is not written to the queue; otherwise it is pushed normally.
  - Redirect in that cycle suppresses inst_valid.
- Undefined: no bypass path; all instructions pass through the queue with 1-cycle latency.

Test Plan:
- Reset release, req_ready=1, imem 1-cycle latency, inst_ready=1 -> requests to 0x0, 0x4, 0x8. inst_pc sequence 0x0, 0x4, 0x8 with matching data. pc_stall=0 on every fire.
- inst_ready=0, DEPTH=2 -> exactly 2 requests issued (0x0, 0x4). Then req_valid=0, pc_stall=1. Queue holds both. After 1 pop, one new request to 0x8.
- req_ready=0 for 3 cycles -> pc_stall=1, pc_addr frozen at 0x4, req_addr=0x4 stable. Issue resumes when req_ready=1.
- Two requests in flight (0x10, 0x14), redirect to 0x100 -> queue empty next cycle. Both responses dropped (discard 2->0). Next inst_pc=0x100.
- Redirect in the same cycle as a response -> that response dropped; discard counts only the remaining stale request. No stale inst_valid ever.
- With IFETCH_BYPASS_EN, empty queue, response data 0x00500093 at pc 0x0 -> inst_valid=1, inst_data=0x00500093 in the rsp_valid cycle. Without the macro, the same values appear one cycle later.

Source files
------------

// File: rtl/ifetch_unit.sv
// ifetch_unit: instruction fetch stage sitting after the PC register.
// Issues in-order imem reads from pc_addr, tracks outstanding requests,
// and queues returned words (with their PCs) for decode.
// Optional macro IFETCH_BYPASS_EN: a response arriving while the queue is empty
// is presented to decode combinationally in the same cycle.
module ifetch_unit #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] pc_addr,
    input  logic            redirect,
    output logic            pc_stall,
    output logic            req_valid,
    output logic [XLEN-1:0] req_addr,
    input  logic            req_ready,
    input  logic            rsp_valid,
    input  logic [XLEN-1:0] rsp_data,
    output logic            inst_valid,
    output logic [XLEN-1:0] inst_data,
    output logic [XLEN-1:0] inst_pc,
    input  logic            inst_ready
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    // Address FIFO: PC of each in-flight request, popped as responses return
    logic [XLEN-1:0] addr_mem [DEPTH];
    logic [PW-1:0]   a_wp, a_rp;

    // Instruction queue feeding decode
    logic [XLEN-1:0] q_data [DEPTH];
    logic [XLEN-1:0] q_pc   [DEPTH];
    logic [PW-1:0]   q_wp, q_rp;

    logic [CW-1:0]   count, inflight, discard;
    logic [CW:0]     occ;
    logic            credit, fire, q_empty, drop, push, pop;
    logic            byp, byp_take;
    logic [XLEN-1:0] rsp_pc;

    // Credit covers every word that may still land in the queue, stale ones included
    always_comb begin
        occ       = {1'b0, inflight} + {1'b0, count};
        credit    = occ < (CW+1)'(DEPTH);
        req_valid = reset & credit & ~redirect;
        req_addr  = pc_addr;
        fire      = req_valid & req_ready;
        pc_stall  = ~reset | ~(fire | redirect);
        q_empty   = (count == '0);
        rsp_pc    = addr_mem[a_rp];
        drop      = redirect | (discard != '0);
`ifdef IFETCH_BYPASS_EN
        byp       = q_empty & (discard == '0) & rsp_valid & ~redirect;
`else
        byp       = 1'b0;
`endif
        byp_take  = byp & inst_ready;
        push      = rsp_valid & ~drop & ~byp_take;
        pop       = ~q_empty & inst_ready & ~redirect;
        inst_valid = ~q_empty | byp;
        inst_data  = byp ? rsp_data : q_data[q_rp];
        inst_pc    = byp ? rsp_pc   : q_pc[q_rp];
    end

    // Request tracking: address FIFO, in-flight and stale-response counters
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_wp     <= '0;
            a_rp     <= '0;
            inflight <= '0;
            discard  <= '0;
            for (int i = 0; i < DEPTH; i++) addr_mem[i] <= '0;
        end else begin
            if (fire) begin
                addr_mem[a_wp] <= pc_addr;
                a_wp           <= a_wp + 1'b1;
            end
            if (rsp_valid) a_rp <= a_rp + 1'b1;
            inflight <= inflight + CW'(fire) - CW'(rsp_valid);
            // On flush every request still pending after this cycle is stale
            if (redirect)
                discard <= inflight - CW'(rsp_valid);
            else if (rsp_valid && discard != '0)
                discard <= discard - 1'b1;
        end
    end

    // Instruction queue: push accepted responses, pop on decode handshake, clear on flush
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q_wp  <= '0;
            q_rp  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                q_data[i] <= '0;
                q_pc[i]   <= '0;
            end
        end else if (redirect) begin
            q_rp  <= q_wp;
            count <= '0;
        end else begin
            if (push) begin
                q_data[q_wp] <= rsp_data;
                q_pc[q_wp]   <= rsp_pc;
                q_wp         <= q_wp + 1'b1;
            end
            if (pop) q_rp <= q_rp + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end

`ifndef SYNTHESIS
    // Responses with nothing outstanding, and queue overflow, are protocol errors
    a_rsp_orphan: assert property (@(posedge clk) disable iff (!reset)
        !(rsp_valid && inflight == '0));
    a_q_overflow: assert property (@(posedge clk) disable iff (!reset)
        !(push && !pop && count == CW'(DEPTH)));
`endif
endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit: models the PC register and a 1-cycle imem
// (word = 0x00500093 + address) and checks fetch order, credit, stalls and flush.
module tb_ifetch_unit;
    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc_addr;
    logic        redirect;
    logic        pc_stall;
    logic        req_valid;
    logic [31:0] req_addr;
    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        inst_valid;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        inst_ready;

    logic        mem_en;
    logic [31:0] pc, tgt;
    logic [31:0] mq[$];
    logic [31:0] req_log[$];
    logic [63:0] inst_log[$];
    int          n_chk = 0;
    int          n_pass = 0;

`ifdef IFETCH_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    always #5 clk = ~clk;

    ifetch_unit #(.XLEN(32), .DEPTH(2)) dut (
        .clk(clk), .reset(reset), .pc_addr(pc_addr), .redirect(redirect),
        .pc_stall(pc_stall), .req_valid(req_valid), .req_addr(req_addr),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .inst_valid(inst_valid), .inst_data(inst_data), .inst_pc(inst_pc),
        .inst_ready(inst_ready)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // One clock: log handshakes, advance PC model and imem model, drive next inputs
    task automatic tick();
        logic f, st, rd;
        logic [31:0] a;
        #1;
        f  = req_valid & req_ready;
        st = pc_stall;
        rd = redirect;
        a  = req_addr;
        if (f) begin
            req_log.push_back(a);
            check("stall_on_fire", {63'd0, st}, 64'd0);
        end
        if (inst_valid && inst_ready && !rd) inst_log.push_back({inst_pc, inst_data});
        @(posedge clk);
        if (f) mq.push_back(a);
        if (!st) pc = rd ? tgt : pc + 32'd4;
        @(negedge clk);
        redirect = 1'b0;
        pc_addr  = pc;
        if (mem_en && mq.size() > 0) begin
            rsp_valid = 1'b1;
            rsp_data  = 32'h00500093 + mq.pop_front();
        end else begin
            rsp_valid = 1'b0;
            rsp_data  = 32'h0;
        end
        #1;
    endtask

    task automatic do_reset(input logic [31:0] start);
        @(negedge clk);
        reset = 1'b0; redirect = 1'b0; req_ready = 1'b0; inst_ready = 1'b0;
        rsp_valid = 1'b0; rsp_data = 32'h0; mem_en = 1'b0;
        mq.delete(); req_log.delete(); inst_log.delete();
        pc = start; pc_addr = start; tgt = 32'h0;
        @(negedge clk);
        reset = 1'b1;
        #1;
    endtask

    initial begin
        reset = 1'b0; redirect = 1'b0; req_ready = 1'b0; inst_ready = 1'b0;
        rsp_valid = 1'b0; rsp_data = 32'h0; mem_en = 1'b0; pc = 32'h0;
        pc_addr = 32'h0; tgt = 32'h0;
        #12;
        check("rst_inst_valid", {63'd0, inst_valid}, 64'd0);
        check("rst_inst_data", {32'd0, inst_data}, 64'd0);
        check("rst_inst_pc", {32'd0, inst_pc}, 64'd0);
        check("rst_req_valid", {63'd0, req_valid}, 64'd0);
        check("rst_pc_stall", {63'd0, pc_stall}, 64'd1);

        // Streaming fetch
        do_reset(32'h0);
        mem_en = 1'b1; req_ready = 1'b1; inst_ready = 1'b1;
        for (int i = 0; i < 12; i++) tick();
        check("t1_nreq", {63'd0, req_log.size() >= 3}, 64'd1);
        check("t1_ninst", {63'd0, inst_log.size() >= 3}, 64'd1);
        if (req_log.size() >= 3) begin
            check("t1_req0", {32'd0, req_log[0]}, 64'h0);
            check("t1_req1", {32'd0, req_log[1]}, 64'h4);
            check("t1_req2", {32'd0, req_log[2]}, 64'h8);
        end
        if (inst_log.size() >= 3) begin
            check("t1_inst0", inst_log[0], 64'h00000000_00500093);
            check("t1_inst1", inst_log[1], 64'h00000004_00500097);
            check("t1_inst2", inst_log[2], 64'h00000008_0050009B);
        end

        // Decode stalled: queue fills, credit stops issue
        do_reset(32'h0);
        mem_en = 1'b1; req_ready = 1'b1; inst_ready = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check("t2_nreq", {32'd0, 32'(req_log.size())}, 64'd2);
        check("t2_req_valid_full", {63'd0, req_valid}, 64'd0);
        check("t2_stall_full", {63'd0, pc_stall}, 64'd1);
        check("t2_head", {inst_valid, 31'd0, inst_pc}, {1'b1, 31'd0, 32'h0});
        check("t2_head_data", {32'd0, inst_data}, 64'h00500093);
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        #1;
        check("t2_req_after_pop", {31'd0, req_valid, req_addr}, {31'd0, 1'b1, 32'h8});
        check("t2_head2", {inst_pc, inst_data}, 64'h00000004_00500097);
        tick();
        check("t2_nreq3", {32'd0, 32'(req_log.size())}, 64'd3);
        check("t2_req_valid_again", {63'd0, req_valid}, 64'd0);

        // Memory not ready: PC frozen
        do_reset(32'h0);
        mem_en = 1'b1; req_ready = 1'b1; inst_ready = 1'b1;
        tick();
        req_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("t3_stall", {63'd0, pc_stall}, 64'd1);
            check("t3_req", {31'd0, req_valid, req_addr}, {31'd0, 1'b1, 32'h4});
            tick();
        end
        req_ready = 1'b1;
        #1;
        check("t3_resume_stall", {63'd0, pc_stall}, 64'd0);
        tick();
        check("t3_nreq", {32'd0, 32'(req_log.size())}, 64'd2);
        if (req_log.size() >= 2) check("t3_req1", {32'd0, req_log[1]}, 64'h4);

        // Redirect with two requests in flight
        do_reset(32'h10);
        req_ready = 1'b1; inst_ready = 1'b1;
        tick(); tick();
        check("t4_credit_out", {63'd0, req_valid}, 64'd0);
        mem_en = 1'b1; redirect = 1'b1; tgt = 32'h100;
        #1;
        check("t4_flush_stall", {63'd0, pc_stall}, 64'd0);
        check("t4_flush_noreq", {63'd0, req_valid}, 64'd0);
        tick();
        check("t4_empty_after", {63'd0, inst_valid}, 64'd0);
        for (int i = 0; i < 20 && inst_log.size() == 0; i++) tick();
        check("t4_got_inst", {63'd0, inst_log.size() != 0}, 64'd1);
        if (inst_log.size() != 0) check("t4_first_inst", inst_log[0], 64'h00000100_00500193);
        check("t4_first_req", {32'd0, req_log[2]}, 64'h100);

        // Redirect coinciding with a response
        do_reset(32'h20);
        req_ready = 1'b1; inst_ready = 1'b1;
        tick(); tick();
        mem_en = 1'b1;
        tick();
        redirect = 1'b1; tgt = 32'h200;
        #1;
        check("t5_rsp_cycle", {63'd0, rsp_valid}, 64'd1);
        check("t5_no_inst_flush", {63'd0, inst_valid}, 64'd0);
        tick();
        check("t5_no_stale", {63'd0, inst_valid}, 64'd0);
        check("t5_req_new", {31'd0, req_valid, req_addr}, {31'd0, 1'b1, 32'h200});
        for (int i = 0; i < 20 && inst_log.size() == 0; i++) tick();
        check("t5_got_inst", {63'd0, inst_log.size() != 0}, 64'd1);
        if (inst_log.size() != 0) check("t5_first_inst", inst_log[0], 64'h00000200_00500293);

        // Response-to-decode latency
        do_reset(32'h0);
        mem_en = 1'b1; req_ready = 1'b1; inst_ready = 1'b0;
        tick();
        check("t6_valid_same", {63'd0, inst_valid}, {63'd0, BYP});
        check("t6_data_same", {32'd0, inst_data}, BYP ? 64'h00500093 : 64'h0);
        tick();
        check("t6_valid_next", {63'd0, inst_valid}, 64'd1);
        check("t6_next", {inst_pc, inst_data}, 64'h00000000_00500093);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
